// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP MAC sequencer: state encoding, OPMODE values
// and datapath widths.
package dsp_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] OPMODE_IDLE = 8'h00;
  localparam logic [7:0] OPMODE_MAC  = 8'h09;  // X=M, Z=P, add

  localparam int A_W = 18;
  localparam int P_W = 48;
endpackage

// File: rtl/dsp_mac_seq_if.sv
// Job / operand / result handshake plus the DSP48A1 control bundle.
interface dsp_mac_seq_if #(parameter int LEN_W = 8);
  import dsp_ctrl_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             start_err;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [A_W-1:0]   in_b;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [P_W-1:0]   result;
  logic [A_W-1:0]   dsp_a;
  logic [A_W-1:0]   dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rst;
  logic [P_W-1:0]   dsp_p;

  modport slave (
    input  start, len, in_valid, in_a, in_b, abort, res_ready, dsp_p,
    output start_err, busy, in_ready, res_valid, result,
           dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst
  );

  modport master (
    output start, len, in_valid, in_a, in_b, abort, res_ready, dsp_p,
    input  start_err, busy, in_ready, res_valid, result,
           dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequences a dot-product job through an external pipelined DSP48A1 MAC:
// feeds operand pairs, waits out the pipeline latency, then hands back P.
module dsp_mac_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic        clk,
  input  logic        RSTN,
  dsp_mac_seq_if.slave bus
);
  localparam int DW = $clog2(PIPE_LAT + 1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [P_W-1:0]   result_q;
  logic             start_err_q;
  logic             accept;
  logic             last_beat;
  logic             mac_on;

  // Ready depends only on state/counter so the producer may wait on it.
  assign bus.in_ready = (state == S_FEED) && (beat_cnt < len_q);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_beat    = accept && (beat_cnt == len_q - LEN_W'(1));
  assign mac_on       = (state == S_FEED) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      result_q    <= '0;
      start_err_q <= 1'b0;
    end else begin
      start_err_q <= 1'b0;
      if (bus.abort && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            if (bus.len == '0) begin
              start_err_q <= 1'b1;
            end else begin
              len_q    <= bus.len;
              beat_cnt <= '0;
              state    <= S_FEED;
            end
          end
          S_FEED: if (accept) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
          // P carries the last product once PIPE_LAT cycles have elapsed.
          S_DRAIN: if (drain_cnt == DW'(PIPE_LAT - 1)) begin
            result_q <= bus.dsp_p;
            state    <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
          S_DONE: if (bus.res_ready) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.start_err  = start_err_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.res_valid  = (state == S_DONE);
  assign bus.result     = result_q;
  assign bus.dsp_ce     = mac_on;
  assign bus.dsp_rst    = (state == S_IDLE);
  assign bus.dsp_opmode = mac_on ? OPMODE_MAC : OPMODE_IDLE;
  // Bubbles present zero so idle FEED cycles add nothing to P.
  assign bus.dsp_a      = accept ? bus.in_a : '0;
  assign bus.dsp_b      = accept ? bus.in_b : '0;
endmodule
